// File: rtl/riscv_lsu_mem_pkg.sv
// Shared LSU definitions: operation codes, funct3 access encodings and FSM states.
package riscv_lsu_mem_pkg;

    localparam int LSU_OPT_WIDTH = 2;

    localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_NONE  = 2'd0;
    localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_LOAD  = 2'd1;
    localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_STORE = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RSP  = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [LSU_OPT_WIDTH-1:0] opt;
        logic [2:0]               funct3;
    } lsu_op_t;

endpackage

// File: rtl/riscv_dff.sv
// Plain register with synchronous active-low reset to a configurable value.
module riscv_dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) q <= RESET_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for the LSU: store strobes/shift, load shift/extend, size legality.
module riscv_lsu_align
    import riscv_lsu_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int OFFW       = $clog2(BYTES)
) (
    input  logic [2:0]            funct3,
    input  logic [OFFW-1:0]       off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [BYTES-1:0]      wstrb,
    output logic [DATA_WIDTH-1:0] wdata_sh,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  misaligned,
    output logic                  illegal
);

    logic [7:0]            lane_mask;
    logic [2:0]            size_m1;
    logic [DATA_WIDTH-1:0] rdata_sh;
    int                    nbits;

    always_comb begin
        lane_mask = 8'hFF;
        size_m1   = 3'd7;
        case (funct3[1:0])
            2'd0: begin lane_mask = 8'h01; size_m1 = 3'd0; end
            2'd1: begin lane_mask = 8'h03; size_m1 = 3'd1; end
            2'd2: begin lane_mask = 8'h0F; size_m1 = 3'd3; end
            default: ;
        endcase

        illegal    = (funct3 == 3'b111) ||
                     (DATA_WIDTH == 32 && (funct3 == F3_LD || funct3 == F3_LWU));
        misaligned = |(off & size_m1[OFFW-1:0]);

        wstrb    = lane_mask[BYTES-1:0] << off;
        wdata_sh = wdata << {off, 3'b000};
        rdata_sh = rdata >> {off, 3'b000};

        // Bits above the access size replicate the top data bit only for signed loads.
        nbits = 8 << funct3[1:0];
        if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
        for (int i = 0; i < DATA_WIDTH; i++)
            rdata_ext[i] = (i < nbits) ? rdata_sh[i] : (~funct3[2] & rdata_sh[nbits-1]);
    end

endmodule

// File: rtl/riscv_lsu_mem.sv
// Multi-cycle load/store unit: one op at a time, aligned bus request, registered completion.
module riscv_lsu_mem
    import riscv_lsu_mem_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int OFFW       = $clog2(BYTES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [LSU_OPT_WIDTH-1:0] lsu_opt,
    input  logic [2:0]               funct3,
    input  logic [ADDR_WIDTH-1:0]    lsu_addr,
    input  logic [DATA_WIDTH-1:0]    lsu_wdata,
    output logic                     lsu_done,
    output logic [DATA_WIDTH-1:0]    lsu_result,
    output logic                     lsu_err,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_wen,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr,
    output logic [DATA_WIDTH-1:0]    mem_req_wdata,
    output logic [BYTES-1:0]         mem_req_wstrb,
    input  logic                     mem_rsp_valid,
    output logic                     mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rsp_rdata,
    input  logic                     mem_rsp_err
);

    lsu_state_e            state, state_nxt;
    logic [1:0]            state_q;
    lsu_op_t               op_q;
    logic [OFFW-1:0]       off_q;
    logic                  accept, is_mem, is_store, bad;
    logic [2:0]            al_f3;
    logic [OFFW-1:0]       al_off;
    logic [BYTES-1:0]      al_wstrb;
    logic [DATA_WIDTH-1:0] al_wdata, al_rext;
    logic                  al_misaligned, al_illegal;
    logic                  done_q, err_q;
    logic [DATA_WIDTH-1:0] result_q;

    riscv_dff #(.WIDTH(2), .RESET_VAL(LSU_IDLE)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_nxt),
        .q     (state_q)
    );
    assign state = lsu_state_e'(state_q);

    // Shared lane logic: decodes the incoming op in IDLE, the captured op afterwards.
    riscv_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3     (al_f3),
        .off        (al_off),
        .wdata      (lsu_wdata),
        .rdata      (mem_rsp_rdata),
        .wstrb      (al_wstrb),
        .wdata_sh   (al_wdata),
        .rdata_ext  (al_rext),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_comb begin
        lsu_ready     = rst_n && (state == LSU_IDLE);
        mem_req_valid = (state == LSU_REQ);
        mem_rsp_ready = (state == LSU_RSP);
        al_f3         = (state == LSU_IDLE) ? funct3 : op_q.funct3;
        al_off        = (state == LSU_IDLE) ? lsu_addr[OFFW-1:0] : off_q;
        accept        = lsu_valid && lsu_ready;
        is_store      = (lsu_opt == LSU_OPT_STORE);
        is_mem        = (lsu_opt == LSU_OPT_LOAD) || is_store;
        bad           = al_illegal || al_misaligned || (is_store && funct3[2]);
        state_nxt     = state;
        case (state)
            LSU_IDLE: if (accept && is_mem && !bad) state_nxt = LSU_REQ;
            LSU_REQ:  if (mem_req_ready)            state_nxt = LSU_RSP;
            LSU_RSP:  if (mem_rsp_valid)            state_nxt = LSU_IDLE;
            default:                                state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            result_q      <= '0;
            op_q          <= '0;
            off_q         <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
        end else begin
            // Completion outputs are a one-cycle pulse; they idle at zero.
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            if (accept) begin
                if (!is_mem) begin
                    done_q   <= 1'b1;
                    result_q <= DATA_WIDTH'(lsu_addr);
                end else if (bad) begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end else begin
                    op_q          <= '{opt: lsu_opt, funct3: funct3};
                    off_q         <= lsu_addr[OFFW-1:0];
                    mem_req_wen   <= is_store;
                    mem_req_addr  <= lsu_addr & ~ADDR_WIDTH'(BYTES - 1);
                    mem_req_wdata <= is_store ? al_wdata : '0;
                    mem_req_wstrb <= is_store ? al_wstrb : '0;
                end
            end
            if (state == LSU_RSP && mem_rsp_valid) begin
                done_q <= 1'b1;
                err_q  <= mem_rsp_err;
                if (!mem_rsp_err && op_q.opt == LSU_OPT_LOAD) result_q <= al_rext;
            end
        end
    end

    assign lsu_done   = done_q;
    assign lsu_err    = err_q;
    assign lsu_result = result_q;

endmodule

// File: tb/tb_riscv_lsu_mem.sv
// Directed bench for riscv_lsu_mem (32- and 64-bit instances) with a spec-level expectation model.
module tb_riscv_lsu_mem;
    import riscv_lsu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [LSU_OPT_WIDTH-1:0] lsu_opt;
    logic [2:0]  funct3;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_wdata, mem_rsp_rdata;
    logic        mem_req_ready, mem_rsp_valid, mem_rsp_err;
    logic        v32, v64, sel64;

    logic        r32_ready, r32_done, r32_err, q32_valid, q32_wen, s32_ready;
    logic [31:0] r32_result, q32_addr, q32_wdata;
    logic [3:0]  q32_wstrb;
    logic        r64_ready, r64_done, r64_err, q64_valid, q64_wen, s64_ready;
    logic [63:0] r64_result, q64_wdata;
    logic [31:0] q64_addr;
    logic [7:0]  q64_wstrb;

    riscv_lsu_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .lsu_valid(v32), .lsu_ready(r32_ready), .lsu_opt(lsu_opt),
        .funct3(funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata[31:0]), .lsu_done(r32_done),
        .lsu_result(r32_result), .lsu_err(r32_err), .mem_req_valid(q32_valid),
        .mem_req_ready(mem_req_ready), .mem_req_wen(q32_wen), .mem_req_addr(q32_addr),
        .mem_req_wdata(q32_wdata), .mem_req_wstrb(q32_wstrb), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_ready(s32_ready), .mem_rsp_rdata(mem_rsp_rdata[31:0]), .mem_rsp_err(mem_rsp_err)
    );

    riscv_lsu_mem #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .lsu_valid(v64), .lsu_ready(r64_ready), .lsu_opt(lsu_opt),
        .funct3(funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_done(r64_done),
        .lsu_result(r64_result), .lsu_err(r64_err), .mem_req_valid(q64_valid),
        .mem_req_ready(mem_req_ready), .mem_req_wen(q64_wen), .mem_req_addr(q64_addr),
        .mem_req_wdata(q64_wdata), .mem_req_wstrb(q64_wstrb), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_ready(s64_ready), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
    );

    // Outputs of whichever instance is under test, widened to 64 bits.
    logic        a_ready, a_done, a_err, a_req_valid, a_wen, a_rsp_ready;
    logic [63:0] a_result, a_wdata;
    logic [31:0] a_addr;
    logic [7:0]  a_wstrb;
    assign a_ready     = sel64 ? r64_ready  : r32_ready;
    assign a_done      = sel64 ? r64_done   : r32_done;
    assign a_err       = sel64 ? r64_err    : r32_err;
    assign a_req_valid = sel64 ? q64_valid  : q32_valid;
    assign a_wen       = sel64 ? q64_wen    : q32_wen;
    assign a_rsp_ready = sel64 ? s64_ready  : s32_ready;
    assign a_result    = sel64 ? r64_result : {32'd0, r32_result};
    assign a_wdata     = sel64 ? q64_wdata  : {32'd0, q32_wdata};
    assign a_addr      = sel64 ? q64_addr   : q32_addr;
    assign a_wstrb     = sel64 ? q64_wstrb  : {4'd0, q32_wstrb};

    typedef struct {
        bit          bus;
        logic [31:0] addr_al;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        wen;
        logic [63:0] result;
        logic        err;
        logic [63:0] rdata;
        logic        rerr;
        int          stall;
        bit          hold;
        int          acc_cyc;
        int          age;
    } exp_t;

    exp_t        exp_q[$];
    int          done_cycs[$];
    int          cyc = 0, checks = 0, errors = 0;
    bit          chk_en = 0;
    logic [63:0] last_res, last_wdata;
    logic        last_err, last_wen;
    logic [31:0] last_addr;
    logic [7:0]  last_wstrb;
    int          last_lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What the unit must do, worked out from address arithmetic on plain integers.
    function automatic exp_t model(int bytes, logic [1:0] opt, logic [2:0] f3, logic [31:0] addr,
                                   logic [63:0] wd, logic [63:0] rd, logic rerr);
        exp_t e;
        int size, off;
        logic [63:0] dmask, m, v;
        e = '{default: 0};
        e.rdata = rd;
        e.rerr  = rerr;
        dmask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (opt != LSU_OPT_LOAD && opt != LSU_OPT_STORE) begin
            e.result = {32'd0, addr};
            return e;
        end
        size = 1 << f3[1:0];
        off  = addr % bytes;
        if (f3 == 3'b111 || (bytes == 4 && (f3 == 3'b011 || f3 == 3'b110)) ||
            (opt == LSU_OPT_STORE && f3[2]) || (addr % size) != 0) begin
            e.err = 1;
            return e;
        end
        e.bus     = 1;
        e.addr_al = addr - off;
        e.wen     = (opt == LSU_OPT_STORE);
        if (e.wen) begin
            e.wdata = (wd << (8 * off)) & dmask;
            e.wstrb = 8'(((1 << size) - 1) << off);
        end else begin
            v = (rd & dmask) >> (8 * off);
            m = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * size)) - 1;
            v = v & m;
            if (!f3[2] && v[8*size-1]) v = v | ~m;
            e.result = v & dmask;
        end
        if (rerr) begin
            e.err    = 1;
            e.result = 0;
        end
        return e;
    endfunction

    // Bus slave: stalls the request per op, answers in the cycle rsp_ready is seen.
    always begin
        @(posedge clk);
        #2;
        mem_req_ready = 0;
        mem_rsp_valid = 0;
        mem_rsp_err   = 0;
        mem_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        if (exp_q.size() > 0) begin
            if (a_req_valid) begin
                if (exp_q[0].stall > 0) exp_q[0].stall = exp_q[0].stall - 1;
                else mem_req_ready = 1;
            end
            if (a_rsp_ready && !exp_q[0].hold) begin
                mem_rsp_valid = 1;
                mem_rsp_rdata = exp_q[0].rdata;
                mem_rsp_err   = exp_q[0].rerr;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lsu_ready", a_ready, !(exp_q.size() > 0 && exp_q[0].bus && !a_done));
            if (a_req_valid) begin
                chk("req_expected", exp_q.size() > 0 && exp_q[0].bus, 1);
                if (exp_q.size() > 0) begin
                    chk("req_addr", a_addr, exp_q[0].addr_al);
                    chk("req_wdata", a_wdata, exp_q[0].wdata);
                    chk("req_wstrb", a_wstrb, exp_q[0].wstrb);
                    chk("req_wen", a_wen, exp_q[0].wen);
                end
                last_addr = a_addr; last_wdata = a_wdata; last_wstrb = a_wstrb; last_wen = a_wen;
            end
            if (a_done) begin
                chk("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("result", a_result, exp_q[0].result);
                    chk("err", a_err, exp_q[0].err);
                    last_lat = cyc - exp_q[0].acc_cyc;
                    void'(exp_q.pop_front());
                end
                last_res = a_result;
                last_err = a_err;
                done_cycs.push_back(cyc);
            end else begin
                chk("result_quiet", a_result, 0);
                chk("err_quiet", a_err, 0);
                if (exp_q.size() > 0) begin
                    exp_q[0].age = exp_q[0].age + 1;
                    if (exp_q[0].age > 50) begin
                        chk("done_timeout", 0, 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input bit is64, input logic [1:0] opt, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input logic rerr, input int stall, input bit hold, output int acc);
        exp_t e;
        bit ok;
        ok = 0;
        e = model(is64 ? 8 : 4, opt, f3, addr, wd, rd, rerr);
        e.stall = stall;
        e.hold  = hold;
        sel64 = is64; lsu_opt = opt; funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
        if (is64) v64 = 1; else v32 = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_ready) begin ok = 1; break; end
        end
        chk("accept_in_time", ok, 1);
        e.acc_cyc = cyc;
        acc = cyc;
        @(posedge clk);
        #1;
        v32 = 0;
        v64 = 0;
        if (ok) exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        chk("drain", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input string name, input logic [63:0] res, input logic err, input int lat);
        chk({name, "_result"}, last_res, res);
        chk({name, "_err"}, last_err, err);
        chk({name, "_latency"}, last_lat, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, n0;
        v32 = 0; v64 = 0; sel64 = 0; lsu_opt = '0; funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_rdata = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst32_ctrl", {r32_ready, r32_done, r32_err, q32_valid, q32_wen, s32_ready}, 0);
        chk("rst32_data", {r32_result, q32_addr}, 0);
        chk("rst32_wr", {q32_wdata, q32_wstrb}, 0);
        chk("rst64_ctrl", {r64_ready, r64_done, r64_err, q64_valid, q64_wen, s64_ready}, 0);
        chk("rst64_data", r64_result | q64_wdata | {32'd0, q64_addr} | {56'd0, q64_wstrb}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("ready_after_reset", {r32_ready, r64_ready}, 2'b11);
        @(posedge clk); #1 chk_en = 1;

        // 32-bit datapath
        issue(0, LSU_OPT_STORE, F3_SB, 32'h8000_0003, 64'h0000_00A5, 0, 0, 0, 0, a0); wait_idle();
        chk("sb_addr", last_addr, 32'h8000_0000);
        chk("sb_wstrb", last_wstrb, 8'b1000);
        chk("sb_wdata", last_wdata, 64'hA500_0000);
        chk("sb_wen", last_wen, 1);
        expect_done("sb", 0, 0, 3);
        issue(0, LSU_OPT_LOAD, F3_LH, 32'h8000_0002, 0, 64'h8001_1234, 0, 0, 0, a0); wait_idle();
        expect_done("lh", 64'hFFFF_8001, 0, 3);
        issue(0, LSU_OPT_LOAD, F3_LHU, 32'h8000_0002, 0, 64'h8001_1234, 0, 0, 0, a0); wait_idle();
        expect_done("lhu", 64'h0000_8001, 0, 3);
        issue(0, LSU_OPT_LOAD, F3_LB, 32'h8000_0001, 0, 64'h0000_8000, 0, 0, 0, a0); wait_idle();
        expect_done("lb", 64'hFFFF_FF80, 0, 3);
        issue(0, LSU_OPT_LOAD, F3_LBU, 32'h8000_0003, 0, 64'h7F00_0000, 0, 0, 0, a0); wait_idle();
        expect_done("lbu", 64'h7F, 0, 3);
        issue(0, LSU_OPT_LOAD, F3_LW, 32'h8000_0004, 0, 64'h1234_5678, 0, 1, 0, a0); wait_idle();
        expect_done("lw", 64'h1234_5678, 0, 4);
        issue(0, LSU_OPT_LOAD, F3_LW, 32'h8000_0002, 0, 0, 0, 0, 0, a0); wait_idle();
        expect_done("lw_misaligned", 0, 1, 1);
        issue(0, LSU_OPT_NONE, 3'b000, 32'h1234_5678, 0, 0, 0, 0, 0, a0); wait_idle();
        expect_done("none", 64'h1234_5678, 0, 1);
        issue(0, LSU_OPT_LOAD, F3_LD, 32'h8000_0008, 0, 0, 0, 0, 0, a0); wait_idle();
        expect_done("ld_on_32", 0, 1, 1);
        issue(0, LSU_OPT_LOAD, F3_LWU, 32'h8000_0008, 0, 0, 0, 0, 0, a0); wait_idle();
        expect_done("lwu_on_32", 0, 1, 1);
        issue(0, LSU_OPT_STORE, 3'b100, 32'h8000_0008, 0, 0, 0, 0, 0, a0); wait_idle();
        expect_done("store_f3_4", 0, 1, 1);
        issue(0, LSU_OPT_STORE, F3_SH, 32'h8000_0002, 64'h1234, 0, 0, 0, 0, a0); wait_idle();
        chk("sh_wstrb", last_wstrb, 8'b1100);
        chk("sh_wdata", last_wdata, 64'h1234_0000);
        issue(0, LSU_OPT_STORE, F3_SW, 32'h8000_0010, 64'hCAFE_BABE, 0, 0, 0, 0, a0); wait_idle();
        chk("sw_wstrb", last_wstrb, 8'b1111);
        issue(0, LSU_OPT_LOAD, F3_LW, 32'h8000_0008, 0, 64'h5555_5555, 1, 3, 0, a0); wait_idle();
        expect_done("bus_err", 0, 1, 6);

        // Reset while waiting for the response
        issue(0, LSU_OPT_LOAD, F3_LW, 32'h8000_000C, 0, 0, 0, 0, 1, a0);
        a1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_rsp_ready) begin a1 = 1; break; end
        end
        chk("reached_rsp", a1, 1);
        @(posedge clk); #1 rst_n = 0; chk_en = 0;
        @(posedge clk); #1 rst_n = 1; exp_q.delete();
        @(negedge clk);
        chk("midrst_ctrl", {r32_done, r32_err, q32_valid, q32_wen, s32_ready, r32_ready}, 6'b000001);
        chk("midrst_data", {r32_result, q32_addr}, 0);
        chk("midrst_wr", {q32_wdata, q32_wstrb}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_done", r32_done, 0);
        end
        @(posedge clk); #1 chk_en = 1;

        // 64-bit datapath
        issue(1, LSU_OPT_LOAD, F3_LD, 32'h8000_0008, 0, 64'h0123_4567_89AB_CDEF, 0, 0, 0, a0); wait_idle();
        chk("ld64_addr", last_addr, 32'h8000_0008);
        expect_done("ld64", 64'h0123_4567_89AB_CDEF, 0, 3);
        issue(1, LSU_OPT_LOAD, F3_LW, 32'h8000_0004, 0, 64'h8000_0000_0000_0000, 0, 0, 0, a0); wait_idle();
        chk("lw64_addr", last_addr, 32'h8000_0000);
        expect_done("lw64", 64'hFFFF_FFFF_8000_0000, 0, 3);
        issue(1, LSU_OPT_LOAD, F3_LWU, 32'h8000_0004, 0, 64'h8000_0000_0000_0000, 0, 0, 0, a0); wait_idle();
        expect_done("lwu64", 64'h0000_0000_8000_0000, 0, 3);
        issue(1, LSU_OPT_STORE, F3_SB, 32'h8000_0005, 64'hA5, 0, 0, 0, 0, a0); wait_idle();
        chk("sb64_wstrb", last_wstrb, 8'h20);
        chk("sb64_wdata", last_wdata, 64'h0000_A500_0000_0000);
        issue(1, LSU_OPT_LOAD, F3_LD, 32'h8000_0004, 0, 0, 0, 0, 0, a0); wait_idle();
        expect_done("ld64_misaligned", 0, 1, 1);
        issue(1, LSU_OPT_LOAD, 3'b111, 32'h8000_0000, 0, 0, 0, 0, 0, a0); wait_idle();
        expect_done("f3_111", 0, 1, 1);

        n0 = done_cycs.size();
        issue(1, LSU_OPT_LOAD, F3_LD, 32'h8000_0010, 0, 64'hFEDC_BA98_7654_3210, 0, 0, 0, a0);
        issue(1, LSU_OPT_STORE, F3_SD, 32'h8000_0018, 64'h1122_3344_5566_7788, 0, 0, 0, 0, a1);
        wait_idle();
        chk("b2b_gap", a1 - a0, 3);
        chk("b2b_in_done_cycle", a1, (done_cycs.size() > n0) ? done_cycs[n0] : -1);
        chk("sd64_wstrb", last_wstrb, 8'hFF);
        chk("sd64_wdata", last_wdata, 64'h1122_3344_5566_7788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
